// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG host driver: TAP state encoding,
// host command opcodes and fixed TMS sequence lengths.
package jtag_pkg;

  // Classic 1149.1 TAP state encoding.
  typedef enum logic [3:0] {
    EXIT2_DR         = 4'h0,
    EXIT1_DR         = 4'h1,
    SHIFT_DR         = 4'h2,
    PAUSE_DR         = 4'h3,
    SELECT_IR_SCAN   = 4'h4,
    UPDATE_DR        = 4'h5,
    CAPTURE_DR       = 4'h6,
    SELECT_DR_SCAN   = 4'h7,
    EXIT2_IR         = 4'h8,
    EXIT1_IR         = 4'h9,
    SHIFT_IR         = 4'hA,
    PAUSE_IR         = 4'hB,
    RUN_TEST_IDLE    = 4'hC,
    UPDATE_IR        = 4'hD,
    CAPTURE_IR       = 4'hE,
    TEST_LOGIC_RESET = 4'hF
  } tap_state_t;

  typedef enum logic [1:0] {
    OP_TLR      = 2'd0,
    OP_IDLE     = 2'd1,
    OP_SHIFT_IR = 2'd2,
    OP_SHIFT_DR = 2'd3
  } host_op_t;

  // TMS cycles outside the data bits for each sequence type.
  localparam int TLR_TMS_LEN = 6;
  localparam int DR_OVERHEAD = 5;
  localparam int IR_OVERHEAD = 6;

  function automatic logic is_shift_state(input tap_state_t s);
    return (s == SHIFT_DR) || (s == SHIFT_IR);
  endfunction

endpackage

// File: rtl/tap_state_tracker.sv
// Shadow model of a target TAP controller: the 16-state next-state function
// of (state, tms) plus the state register, clocked with the target.
module tap_state_tracker
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       reset,
  input  logic       tms,
  output tap_state_t state,
  output tap_state_t next_state
);

  // Standard TAP transition graph.
  always_comb begin
    // NOTE: a default assignment ahead of the case keeps every path driven, so no latch is inferred.
    next_state = TEST_LOGIC_RESET;
    case (state)
      TEST_LOGIC_RESET: next_state = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    next_state = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   next_state = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       next_state = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         next_state = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         next_state = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         next_state = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         next_state = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        next_state = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   next_state = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       next_state = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         next_state = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         next_state = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         next_state = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         next_state = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        next_state = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          next_state = TEST_LOGIC_RESET;
    endcase
  end

  // State register; reset matches the TMS-high reset value of the host.
  always_ff @(posedge tck) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) state <= TEST_LOGIC_RESET;
    else       state <= next_state;
  end

endmodule

// File: rtl/jtag_host_driver.sv
// JTAG host driver: converts TLR / IDLE / SHIFT_IR / SHIFT_DR commands into
// registered TMS/TDI sequences, captures TDO during shift states and returns
// it in a one-cycle response. Optional expected-value compare is enabled by
// defining JTAG_HOST_EXPECT_EN.
module jtag_host_driver
  import jtag_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               tck,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [CNT_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
`ifdef JTAG_HOST_EXPECT_EN
  input  logic [MAX_LEN-1:0] cmd_expect,
  input  logic [MAX_LEN-1:0] cmd_mask,
  output logic               rsp_mismatch,
`endif
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic [3:0]         tap_state,
  output logic               busy
);

  typedef enum logic [1:0] {ST_INIT, ST_WAIT, ST_RUN} fsm_t;

  fsm_t               fsm;
  host_op_t           op;
  logic [CNT_W-1:0]   len;
  logic [CNT_W-1:0]   cnt;       // TLR: next cycle index; IDLE: cycles left; SHIFT: bits left after current
  logic [MAX_LEN-1:0] data;
  logic [MAX_LEN-1:0] cap;
  logic [MAX_LEN-1:0] bit_mask;  // one-hot position of the bit in the current shift cycle
`ifdef JTAG_HOST_EXPECT_EN
  logic [MAX_LEN-1:0] exp_q;
  logic [MAX_LEN-1:0] msk_q;
`endif

  tap_state_t         cur_state;
  tap_state_t         nxt_state;

  logic               in_shift;
  logic [CNT_W-1:0]   shift_rem;
  logic [MAX_LEN-1:0] next_mask;
  logic [MAX_LEN-1:0] cap_next;
  logic               done;
  host_op_t           cmd_op_e;
  logic               cmd_bad;
  logic               cmd_now;

  tap_state_tracker u_tracker (
    .tck        (tck),
    .reset      (reset),
    .tms        (tms),
    .state      (cur_state),
    .next_state (nxt_state)
  );

  assign tap_state = cur_state;
  assign busy      = ~cmd_ready;

  // Sequencing helpers derived from the shadow state and latched command.
  always_comb begin
    in_shift  = is_shift_state(cur_state);
    shift_rem = in_shift ? cnt : len;
    next_mask = in_shift ? (bit_mask << 1) : {{(MAX_LEN-1){1'b0}}, 1'b1};
    cap_next  = (in_shift && tdo) ? (cap | bit_mask) : cap;
    done      = (op == OP_IDLE) ? (cnt == CNT_W'(1)) : (nxt_state == RUN_TEST_IDLE);
    cmd_op_e  = host_op_t'(cmd_op);
    cmd_bad   = ((cmd_op_e == OP_SHIFT_IR) || (cmd_op_e == OP_SHIFT_DR)) &&
                ((cmd_len == '0) || (cmd_len > CNT_W'(MAX_LEN)));
    cmd_now   = cmd_bad || ((cmd_op_e == OP_IDLE) && (cmd_len == '0));
  end

  // Host FSM: init walk to Idle, command acceptance, TMS/TDI generation and response.
  always_ff @(posedge tck) begin
    if (reset) begin
      fsm       <= ST_INIT;
      op        <= OP_TLR;
      len       <= '0;
      cnt       <= CNT_W'(1);
      data      <= '0;
      cap       <= '0;
      bit_mask  <= '0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
`ifdef JTAG_HOST_EXPECT_EN
      exp_q        <= '0;
      msk_q        <= '0;
      rsp_mismatch <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (fsm)
        ST_WAIT: begin
          if (cmd_valid) begin
            op   <= cmd_op_e;
            len  <= cmd_len;
            data <= cmd_data;
            cap  <= '0;
`ifdef JTAG_HOST_EXPECT_EN
            exp_q <= cmd_expect;
            msk_q <= cmd_mask;
`endif
            if (cmd_now) begin
              // Rejected shifts and zero-length idles answer at once without TMS activity.
              rsp_valid <= 1'b1;
              rsp_err   <= cmd_bad;
              rsp_data  <= '0;
`ifdef JTAG_HOST_EXPECT_EN
              rsp_mismatch <= |(cmd_expect & cmd_mask);
`endif
            end else begin
              fsm       <= ST_RUN;
              cmd_ready <= 1'b0;
              tms       <= (cmd_op_e != OP_IDLE);
              cnt       <= (cmd_op_e == OP_IDLE) ? cmd_len : CNT_W'(1);
            end
          end
        end

        default: begin  // ST_INIT and ST_RUN share the sequencer
          cap <= cap_next;
          if (done) begin
            fsm       <= ST_WAIT;
            cmd_ready <= 1'b1;
            tms       <= 1'b0;
            tdi       <= 1'b0;
            if (fsm == ST_RUN) begin
              rsp_valid <= 1'b1;
              rsp_data  <= cap_next;
`ifdef JTAG_HOST_EXPECT_EN
              rsp_mismatch <= |((cap_next ^ exp_q) & msk_q);
`endif
            end
          end else begin
            tdi <= 1'b0;
            case (op)
              OP_TLR: begin
                tms <= (cnt < CNT_W'(TLR_TMS_LEN - 1));
                cnt <= cnt + CNT_W'(1);
              end
              OP_IDLE: begin
                tms <= 1'b0;
                cnt <= cnt - CNT_W'(1);
              end
              default: begin
                case (nxt_state)
                  SELECT_DR_SCAN: tms <= (op == OP_SHIFT_IR);
                  SHIFT_DR, SHIFT_IR: begin
                    tms      <= (shift_rem == CNT_W'(1));
                    cnt      <= shift_rem - CNT_W'(1);
                    bit_mask <= next_mask;
                    tdi      <= |(data & next_mask);
                  end
                  EXIT1_DR, EXIT1_IR: tms <= 1'b1;
                  default:            tms <= 1'b0;
                endcase
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
